// File: rtl/flight_pkg.sv
// Shared command codes, one-hot selector constants and state encodings for
// the flight-mode command sequencer.
package flight_pkg;

  localparam logic [2:0] CMD_NOP     = 3'b000;
  localparam logic [2:0] CMD_ATTACK  = 3'b001;
  localparam logic [2:0] CMD_DEFENSE = 3'b010;
  localparam logic [2:0] CMD_STEALTH = 3'b011;
  localparam logic [2:0] CMD_WARP    = 3'b100;
  localparam logic [2:0] CMD_HALT    = 3'b101;

  localparam logic [3:0] MODE_RESET   = 4'b0001;
  localparam logic [3:0] MODE_ATTACK  = 4'b0010;
  localparam logic [3:0] MODE_DEFENSE = 4'b0100;
  localparam logic [3:0] MODE_STEALTH = 4'b1000;

  localparam logic [3:0] POS_ZERO   = 4'b0001;
  localparam logic [3:0] POS_NORMAL = 4'b0010;
  localparam logic [3:0] POS_JUMP   = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DEFENSE,
    ST_STEALTH
  } mode_state_t;

  typedef enum logic [1:0] {
    WS_NONE,
    WS_CHARGE,
    WS_JUMP,
    WS_COOLDOWN
  } warp_state_t;

  function automatic logic [3:0] mode_onehot(input mode_state_t s);
    case (s)
      ST_ATTACK:  return MODE_ATTACK;
      ST_DEFENSE: return MODE_DEFENSE;
      ST_STEALTH: return MODE_STEALTH;
      default:    return MODE_RESET;
    endcase
  endfunction

  // IDLE forces zero position; the jump selector only exists for the JUMP cycle.
  function automatic logic [3:0] pos_onehot(input mode_state_t m, input warp_state_t w);
    if (m == ST_IDLE)      return POS_ZERO;
    else if (w == WS_JUMP) return POS_JUMP;
    else                   return POS_NORMAL;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count;

  assign done = (count == '0);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && !done) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/flight_mode_ctrl.sv
// Pilot command sequencer: mode FSM, warp charge/jump/cooldown FSM and the
// stealth time limit, driving registered one-hot velocity/position selectors.
module flight_mode_ctrl
  import flight_pkg::*;
#(
  parameter int WARP_CHARGE   = 8,
  parameter int WARP_COOLDOWN = 16,
  parameter int STEALTH_MAX   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_code,
  output logic       cmd_ready,
  output logic [3:0] mode_sel,
  output logic [3:0] pos_sel,
  output logic       warp_busy,
  output logic       cmd_err
);

  localparam int WARP_MAX = (WARP_COOLDOWN > WARP_CHARGE) ? WARP_COOLDOWN : WARP_CHARGE;
  localparam int WW       = $clog2(WARP_MAX + 1);
  localparam int SW       = $clog2(STEALTH_MAX + 1);

  mode_state_t mode_q, mode_d;
  warp_state_t warp_q, warp_d;

  logic          accept;
  logic          cmd_taken;
  logic          err_d;
  logic          wt_load, wt_en, wt_done;
  logic [WW-1:0] wt_value;
  logic          st_load, st_en, st_done;
  logic [SW-1:0] st_value;

  assign accept = cmd_valid && cmd_ready;

  cycle_timer #(.WIDTH(WW)) u_warp_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (wt_load),
    .load_value (wt_value),
    .en         (wt_en),
    .done       (wt_done)
  );

  cycle_timer #(.WIDTH(SW)) u_stealth_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (st_load),
    .load_value (st_value),
    .en         (st_en),
    .done       (st_done)
  );

  // NOTE: every signal written here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    mode_d    = mode_q;
    warp_d    = warp_q;
    err_d     = 1'b0;
    cmd_taken = 1'b0;
    wt_load   = 1'b0;
    wt_value  = '0;
    wt_en     = 1'b0;
    st_load   = 1'b0;
    st_value  = '0;
    st_en     = 1'b0;

    // Warp sequencing runs on its own; commands below may override it.
    case (warp_q)
      WS_CHARGE: begin
        if (wt_done) warp_d = WS_JUMP;
        else         wt_en  = 1'b1;
      end
      WS_JUMP: begin
        warp_d   = WS_COOLDOWN;
        wt_load  = 1'b1;
        wt_value = WW'(WARP_COOLDOWN - 1);
      end
      WS_COOLDOWN: begin
        if (wt_done) warp_d = WS_NONE;
        else         wt_en  = 1'b1;
      end
      default: ;
    endcase

    if (accept) begin
      case (cmd_code)
        CMD_NOP: ;
        CMD_ATTACK: begin
          mode_d    = ST_ATTACK;
          cmd_taken = 1'b1;
        end
        CMD_DEFENSE: begin
          mode_d    = ST_DEFENSE;
          cmd_taken = 1'b1;
        end
        CMD_STEALTH: begin
          mode_d    = ST_STEALTH;
          cmd_taken = 1'b1;
          st_load   = 1'b1;
          st_value  = SW'(STEALTH_MAX - 1);
        end
        CMD_WARP: begin
          // Only NONE or COOLDOWN can be seen here: ready is low otherwise.
          if (mode_q == ST_IDLE || warp_q == WS_COOLDOWN) begin
            err_d = 1'b1;
          end else begin
            warp_d    = WS_CHARGE;
            cmd_taken = 1'b1;
            wt_load   = 1'b1;
            wt_value  = WW'(WARP_CHARGE - 1);
          end
        end
        CMD_HALT: begin
          mode_d    = ST_IDLE;
          warp_d    = WS_NONE;
          cmd_taken = 1'b1;
        end
        default: err_d = 1'b1;
      endcase
    end

    // Stealth limit: a real command wins; NOP, errors and stalled cycles do not.
    if (mode_q == ST_STEALTH && !st_load) begin
      if (st_done && !cmd_taken) begin
        mode_d = ST_DEFENSE;
      end else if (warp_q != WS_CHARGE && warp_q != WS_JUMP) begin
        st_en = 1'b1;
      end
    end

    if (mode_d != ST_STEALTH) begin
      st_load  = 1'b1;
      st_value = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= ST_IDLE;
      warp_q    <= WS_NONE;
      mode_sel  <= MODE_RESET;
      pos_sel   <= POS_ZERO;
      cmd_ready <= 1'b1;
      warp_busy <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      warp_q    <= warp_d;
      mode_sel  <= mode_onehot(mode_d);
      pos_sel   <= pos_onehot(mode_d, warp_d);
      cmd_ready <= (warp_d != WS_CHARGE) && (warp_d != WS_JUMP);
      warp_busy <= (warp_d != WS_NONE);
      cmd_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_flight_mode_ctrl.sv
// Directed self-checking bench for flight_mode_ctrl with default parameters
// (charge 8, cooldown 16, stealth limit 32).
module tb_flight_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;
  logic [3:0] mode_sel;
  logic [3:0] pos_sel;
  logic       warp_busy;
  logic       cmd_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  flight_mode_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_ready (cmd_ready),
    .mode_sel  (mode_sel),
    .pos_sel   (pos_sel),
    .warp_busy (warp_busy),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] m, input logic [3:0] p,
                           input logic r, input logic b, input logic e);
    check({tag, "_mode"},  mode_sel,             m);
    check({tag, "_pos"},   pos_sel,              p);
    check({tag, "_ready"}, {3'b000, cmd_ready},  {3'b000, r});
    check({tag, "_busy"},  {3'b000, warp_busy},  {3'b000, b});
    check({tag, "_err"},   {3'b000, cmd_err},    {3'b000, e});
  endtask

  // Inputs are applied just after a falling edge; outputs read at the next one.
  task automatic step(input logic v, input logic [2:0] c);
    cmd_valid = v;
    cmd_code  = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_code  = 3'b000;
    repeat (2) @(negedge clk);
    check_all("reset", 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;

    step(1'b1, 3'b001);
    check_all("attack", 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'b010);
    check_all("defense", 4'b0100, 4'b0010, 1'b1, 1'b0, 1'b0);

    // Full warp from DEFENSE; HALT offered while not ready must be ignored.
    step(1'b1, 3'b100);
    for (int i = 1; i <= 26; i++) begin
      check($sformatf("w1_mode_%0d", i),  mode_sel, 4'b0100);
      check($sformatf("w1_pos_%0d", i),   pos_sel, (i == 9) ? 4'b0100 : 4'b0010);
      check($sformatf("w1_ready_%0d", i), {3'b000, cmd_ready}, {3'b000, (i > 9)});
      check($sformatf("w1_busy_%0d", i),  {3'b000, warp_busy}, {3'b000, (i <= 25)});
      check($sformatf("w1_err_%0d", i),   {3'b000, cmd_err}, 4'b0000);
      step((i == 2 || i == 3), 3'b101);
    end

    // WARP from IDLE is rejected.
    step(1'b1, 3'b101);
    check_all("halt", 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'b100);
    check_all("warp_idle", 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1);
    step(1'b0, 3'b000);
    check_all("warp_idle_after", 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);

    // WARP five cycles into cooldown is rejected; cooldown length unaffected.
    step(1'b1, 3'b001);
    check_all("attack2", 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'b100);
    for (int i = 1; i <= 26; i++) begin
      check($sformatf("w2_mode_%0d", i), mode_sel, 4'b0010);
      check($sformatf("w2_err_%0d", i),  {3'b000, cmd_err}, {3'b000, (i == 15)});
      check($sformatf("w2_busy_%0d", i), {3'b000, warp_busy}, {3'b000, (i <= 25)});
      step((i == 14), 3'b100);
    end

    // HALT during cooldown, then ATTACK and WARP are accepted.
    step(1'b1, 3'b100);
    for (int i = 1; i < 12; i++) step(1'b0, 3'b000);
    check_all("w3_cooldown", 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0);
    step(1'b1, 3'b101);
    check_all("halt_cool", 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'b001);
    check_all("attack3", 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'b100);
    check_all("warp3", 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-CHARGE; no jump selector while held.
    step(1'b0, 3'b000);
    step(1'b0, 3'b000);
    #2 rst_n = 1'b0;
    #1 check_all("rst_charge", 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("rst_pos_%0d", i), pos_sel, 4'b0001);
    end
    rst_n = 1'b1;

    // Stealth timeout after exactly 32 cycles with NOPs offered.
    step(1'b1, 3'b011);
    for (int i = 1; i <= 40; i++) begin
      check($sformatf("st_mode_%0d", i), mode_sel, (i <= 32) ? 4'b1000 : 4'b0100);
      check($sformatf("st_pos_%0d", i),  pos_sel, 4'b0010);
      step(1'b1, 3'b000);
    end

    // ATTACK on the timeout edge wins.
    step(1'b1, 3'b011);
    for (int i = 1; i < 32; i++) step(1'b0, 3'b000);
    check("st2_mode_32", mode_sel, 4'b1000);
    step(1'b1, 3'b001);
    check("st2_mode_33", mode_sel, 4'b0010);
    step(1'b0, 3'b000);
    check("st2_mode_34", mode_sel, 4'b0010);

    // Illegal codes pulse cmd_err per accepted command without state change.
    step(1'b1, 3'b110);
    check_all("ill_110", 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1);
    step(1'b1, 3'b111);
    check_all("ill_111", 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1);
    step(1'b0, 3'b000);
    check_all("ill_after", 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0);

    // Re-commanding STEALTH at cycle 20 restarts the limit.
    step(1'b1, 3'b011);
    for (int i = 1; i < 20; i++) step(1'b0, 3'b000);
    step(1'b1, 3'b011);
    check("st3_recmd_err", {3'b000, cmd_err}, 4'b0000);
    for (int i = 1; i < 32; i++) step(1'b0, 3'b000);
    check("st3_mode_52", mode_sel, 4'b1000);
    step(1'b0, 3'b000);
    check("st3_mode_53", mode_sel, 4'b0100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
